// File: rtl/key_press_classifier.sv
// ---------------------------------------------------------------------------
// key_press_classifier
//
// Purpose:
//   Debounces a bouncing, active-low push-button. It classifies each accepted
//   press as either short or long. A short press is reported when the key is
//   released. A long press is reported when the hold time expires. While a
//   long press is held, the block can optionally emit periodic auto-repeat
//   strobes.
//
// Parameters:
//   DEB_MAX    - debounce window in clk cycles (press and release)
//   LONG_MAX   - hold time in clk cycles after press acceptance for a long press
//   REPEAT_MAX - auto-repeat period in clk cycles while held long
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   key_in       in   raw push-button, active-low, asynchronous to clk
//   key_level    out  debounced pressed state, 1 = pressed
//   short_pulse  out  one-cycle strobe on debounced release of a short press
//   long_pulse   out  one-cycle strobe when the hold time reaches LONG_MAX
//   repeat_pulse out  one-cycle auto-repeat strobe while held long
//
// Configuration:
//   KEY_REPEAT_EN - when defined, the auto-repeat counter is built and
//                   repeat_pulse is active. When undefined, the counter is
//                   absent and repeat_pulse is tied to 0.
// ---------------------------------------------------------------------------
module key_press_classifier #(
  parameter int DEB_MAX    = 1_000_000,
  parameter int LONG_MAX   = 50_000_000,
  parameter int REPEAT_MAX = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  // A window of one cycle would give a zero-width counter.
  // A repeat period of one cycle would make repeat_pulse follow long_pulse
  // back-to-back. Both cases are rejected at elaboration.
  if (DEB_MAX < 2 || LONG_MAX < 2 || REPEAT_MAX < 2) begin : g_bad_params
    $error("key_press_classifier: DEB_MAX, LONG_MAX and REPEAT_MAX must be >= 2");
  end

  localparam int DEB_W  = $clog2(DEB_MAX);
  localparam int HOLD_W = $clog2(LONG_MAX);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MAX - 1);

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_MAX);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MAX - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DEB,
    PRESSED,
    LONG_HELD,
    RELEASE_DEB
  } state_t;

  state_t state;

  logic sync_p0;
  logic key_s;

  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              was_long;

`ifdef KEY_REPEAT_EN
  logic [REP_W-1:0]  rep_cnt;
`endif

  // Stage boundary: two-flop synchronizer. It resets to the released level (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      key_s   <= 1'b1;
    end else begin
      sync_p0 <= key_in;
      key_s   <= sync_p0;
    end
  end

  // Stage boundary: classifier FSM with registered outputs.
  // Every counter stops at its terminal value and is then cleared by a state
  // transition, so none of them can wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      was_long    <= 1'b0;
      key_level   <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
`endif
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_pulse <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (!key_s) begin
            state   <= PRESS_DEB;
            deb_cnt <= '0;
          end
        end

        PRESS_DEB: begin
          if (key_s) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= PRESSED;
            hold_cnt  <= '0;
            key_level <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        PRESSED: begin
          if (key_s) begin
            state    <= RELEASE_DEB;
            deb_cnt  <= '0;
            was_long <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= LONG_HELD;
            long_pulse <= 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt    <= '0;
`endif
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        LONG_HELD: begin
          // hold_cnt stays frozen at its terminal value here.
          if (key_s) begin
            state    <= RELEASE_DEB;
            deb_cnt  <= '0;
            was_long <= 1'b1;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            repeat_pulse <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
`endif
        end

        RELEASE_DEB: begin
          // A bounce during release resumes the originating state. hold_cnt
          // and rep_cnt were paused here, so timing continues where it left off.
          if (!key_s) begin
            state <= was_long ? LONG_HELD : PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= IDLE;
            key_level   <= 1'b0;
            short_pulse <= !was_long;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef KEY_REPEAT_EN
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/key_press_classifier.md
KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 SHALL have parameter DEB_MAX, default 1_000_000, debounce window in clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_MAX, default 50_000_000, hold time in clk cycles after press acceptance for a long press (1 s).
REQ-003 SHALL have parameter REPEAT_MAX, default 10_000_000, auto-repeat period in clk cycles (200 ms).
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_in  input  1  raw push-button, active-low, asynchronous to clk, bouncing.
REQ-007 SHALL have port key_level  output  1  debounced pressed state, 1 = pressed.
REQ-008 SHALL have port short_pulse  output  1  one-cycle strobe on debounced release of a short press.
REQ-009 SHALL have port long_pulse  output  1  one-cycle strobe when hold time reaches LONG_MAX.
REQ-010 SHALL have port repeat_pulse  output  1  one-cycle auto-repeat strobe while held long.

Function
REQ-011 SHALL pass key_in through a 2-flop synchronizer, both flops resetting to 1, producing key_s; all logic below uses key_s only.
REQ-012 SHALL implement FSM states IDLE, PRESS_DEB, PRESSED, LONG_HELD, RELEASE_DEB.
REQ-013 IDLE: key_s==0 -> PRESS_DEB with deb_cnt cleared to 0.
REQ-014 PRESS_DEB: key_s==1 -> IDLE (bounce rejected, no output); key_s==0 and deb_cnt==DEB_MAX-1 -> PRESSED, hold_cnt cleared, key_level set; otherwise deb_cnt increments.
REQ-015 PRESSED: key_s==1 -> RELEASE_DEB, deb_cnt cleared, was_long=0; else hold_cnt==LONG_MAX-1 -> LONG_HELD, long_pulse=1 for one cycle, rep_cnt cleared; else hold_cnt increments.
REQ-016 LONG_HELD: key_s==1 -> RELEASE_DEB, deb_cnt cleared, was_long=1; hold_cnt frozen.
REQ-017 RELEASE_DEB: key_s==0 -> return to originating state (PRESSED or LONG_HELD) with hold_cnt/rep_cnt unchanged; key_s==1 and deb_cnt==DEB_MAX-1 -> IDLE, key_level cleared, short_pulse=1 for one cycle only if was_long==0; otherwise deb_cnt increments.
REQ-018 hold_cnt SHALL pause (not increment, not clear) during RELEASE_DEB.
REQ-019 deb_cnt SHALL be $clog2(DEB_MAX) bits, hold_cnt $clog2(LONG_MAX) bits, rep_cnt $clog2(REPEAT_MAX) bits; none SHALL wrap.
REQ-020 All outputs SHALL be registered; pulse outputs SHALL never be high for two consecutive cycles and never simultaneously.
REQ-021 Press acceptance latency: key_level rises 2+DEB_MAX+1 cycles after key_in falls (clean edge).

Reset
REQ-022 rst_n low SHALL asynchronously force FSM=IDLE, all counters=0, was_long=0, synchronizer=1, key_level=0, short_pulse=0, long_pulse=0, repeat_pulse=0.
REQ-023 Reset mid-press SHALL discard the press; after release of reset with key still held, a fresh PRESS_DEB SHALL be required before key_level rises; no pulse SHALL be emitted for the discarded press.

Configuration
REQ-024 Macro KEY_REPEAT_EN defined: in LONG_HELD, rep_cnt increments each cycle; at rep_cnt==REPEAT_MAX-1 repeat_pulse=1 for one cycle and rep_cnt clears; rep_cnt pauses in RELEASE_DEB.
REQ-025 Macro KEY_REPEAT_EN undefined: rep_cnt logic absent; repeat_pulse tied to 0.

Verification (DEB_MAX=4, LONG_MAX=20, REPEAT_MAX=8; cycles counted from key_in falling edge)
REQ-026 Reset asserted with key_in=1 -> all outputs 0; release reset, idle 50 cycles -> outputs stay 0.
REQ-027 key_in low 3 cycles then high -> key_level never rises, no pulses.
REQ-028 key_in low 12 cycles then high -> key_level rises at cycle 7, short_pulse one cycle as key_level falls, long_pulse never.
REQ-029 key_in low 40 cycles -> long_pulse once at cycle 27; on release key_level falls, short_pulse stays 0.
REQ-030 Press held, key_in high 2 cycles at cycle 15 -> key_level stays 1, no pulses, long_pulse delayed by the 3 RELEASE_DEB cycles (cycle 30).
REQ-031 KEY_REPEAT_EN defined, key_in low 70 cycles -> repeat_pulse at cycles 35, 43, 51, 59, 67; undefined -> repeat_pulse never; reset at cycle 20 -> all outputs 0 immediately, no long_pulse.
